sha1_msg_sequencer: RTL and testbench



---
 rtl/sha1_msg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sha1_msg_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_sequencer.sv
// SHA-1 message sequencer: packs a 32-bit big-endian word stream into 512-bit
// blocks, appends the 0x80 marker, zero fill and 64-bit bit-length trailer,
// issues one core_start per block and returns the final digest.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        message word handshake
//   in_data, in_last         word (first byte in [31:24]), final-word marker
//   in_bytes                 valid bytes (0..4, MSB-first) of the final word
//   core_start, core_first   block start pulse; 1 = core loads IV
//   core_block               block to core, word 0 in [511:480]
//   core_done, core_digest   core completion pulse and chaining value H0..H4
//   digest_valid/ready       final digest handshake
//   digest                   final message digest
//   busy                     message in progress
module sha1_msg_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_bytes,
   output logic         core_start,
   output logic         core_first,
   output logic [511:0] core_block,
   input  logic         core_done,
   input  logic [159:0] core_digest,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [159:0] digest,
   output logic         busy
);

   localparam int unsigned NWORDS = 16;

   typedef enum logic [2:0] {IDLE, FILL, RUN, PAD, RUN_PAD, OUT} state_t;

   state_t      state;
   logic [31:0] words [NWORDS];
   logic [4:0]  word_cnt;
   logic [63:0] bit_len;
   logic        first_blk;
   logic        pad_pending;   // a length-only block still has to be sent
   logic        mark_pending;  // that block also carries 0x80000000 at word 0
   logic [2:0]  last_n;        // valid bytes of the final word (4 = full)

   logic        xfer;
   logic [63:0] len_inc;
   logic [3:0]  last_w;
   logic [4:0]  pad_idx;
   logic [31:0] tail_word;

   assign xfer = in_valid & in_ready;

   // Bits contributed by the accepted word.
   assign len_inc = in_last ? {58'd0, in_bytes, 3'd0} : 64'd32;

   // Index of the final word and of the word that receives the 0x80 marker.
   assign last_w  = 4'(word_cnt - 5'd1);
   assign pad_idx = (last_n >= 3'd4) ? word_cnt : {1'b0, last_w};

   // Partial final word: keep the valid bytes, insert 0x80, clear the rest.
   always_comb begin
      tail_word = 32'h8000_0000;
      case (last_n)
         3'd1:    tail_word = {words[last_w][31:24], 24'h80_0000};
         3'd2:    tail_word = {words[last_w][31:16], 16'h8000};
         3'd3:    tail_word = {words[last_w][31:8], 8'h80};
         default: tail_word = 32'h8000_0000;
      endcase
   end

   // The word buffer is the block presented to the core.
   for (genvar g = 0; g < NWORDS; g++) begin : g_blk
      assign core_block[511 - 32*g -: 32] = words[g];
   end

   // Sequencer state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         in_ready     <= 1'b0;
         core_start   <= 1'b0;
         core_first   <= 1'b0;
         digest_valid <= 1'b0;
         digest       <= '0;
         busy         <= 1'b0;
         word_cnt     <= '0;
         bit_len      <= '0;
         first_blk    <= 1'b1;
         pad_pending  <= 1'b0;
         mark_pending <= 1'b0;
         last_n       <= '0;
         for (int i = 0; i < NWORDS; i++) words[i] <= '0;
      end else begin
         core_start <= 1'b0;
         case (state)
            IDLE: begin
               in_ready     <= 1'b1;
               word_cnt     <= '0;
               bit_len      <= '0;
               first_blk    <= 1'b1;
               pad_pending  <= 1'b0;
               mark_pending <= 1'b0;
               if (xfer) begin
                  words[0] <= in_data;
                  word_cnt <= 5'd1;
                  bit_len  <= len_inc;
                  last_n   <= in_last ? in_bytes : 3'd4;
                  busy     <= 1'b1;
                  if (in_last) begin
                     state    <= PAD;
                     in_ready <= 1'b0;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               if (xfer) begin
                  words[word_cnt[3:0]] <= in_data;
                  word_cnt <= word_cnt + 5'd1;
                  bit_len  <= bit_len + len_inc;
                  last_n   <= in_last ? in_bytes : 3'd4;
                  if (in_last) begin
                     state    <= PAD;
                     in_ready <= 1'b0;
                  end else if (word_cnt == 5'd15) begin
                     state      <= RUN;
                     in_ready   <= 1'b0;
                     core_start <= 1'b1;
                     core_first <= first_blk;
                  end
               end
            end
            RUN: begin
               if (core_done) begin
                  first_blk <= 1'b0;
                  word_cnt  <= '0;
                  if (pad_pending) begin
                     state <= PAD;
                  end else begin
                     state    <= FILL;
                     in_ready <= 1'b1;
                  end
               end
            end
            PAD: begin
               core_start <= 1'b1;
               core_first <= first_blk;
               if (pad_pending) begin
                  // Length-only trailer block.
                  for (int i = 0; i < 14; i++) words[i] <= '0;
                  if (mark_pending) words[0] <= 32'h8000_0000;
                  words[14]    <= bit_len[63:32];
                  words[15]    <= bit_len[31:0];
                  pad_pending  <= 1'b0;
                  mark_pending <= 1'b0;
                  state        <= RUN_PAD;
               end else begin
                  for (int i = 0; i < NWORDS; i++) begin
                     if (5'(i) == pad_idx)
                        words[i] <= (last_n >= 3'd4) ? 32'h8000_0000 : tail_word;
                     else if (5'(i) > pad_idx)
                        words[i] <= '0;
                  end
                  if (pad_idx <= 5'd13) begin
                     words[14] <= bit_len[63:32];
                     words[15] <= bit_len[31:0];
                     state     <= RUN_PAD;
                  end else begin
                     // No room for the length: this block goes out without it.
                     pad_pending  <= 1'b1;
                     mark_pending <= (pad_idx == 5'd16);
                     state        <= RUN;
                  end
               end
            end
            RUN_PAD: begin
               if (core_done) begin
                  digest       <= core_digest;
                  digest_valid <= 1'b1;
                  state        <= OUT;
               end
            end
            OUT: begin
               if (digest_ready) begin
                  digest_valid <= 1'b0;
                  busy         <= 1'b0;
                  in_ready     <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_msg_sequencer.sv
// Bench for sha1_msg_sequencer: behavioural SHA-1 core, word-stream driver
// and directed messages with known digests.
module tb_sha1_msg_sequencer;

   typedef logic [7:0] u8;
   typedef u8 bq_t[$];

   localparam logic [159:0] IV        = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
   localparam logic [159:0] D_EMPTY   = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
   localparam logic [159:0] D_ABC     = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
   localparam logic [159:0] D_56      = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, in_last, core_start, core_first, core_done;
   logic [31:0]  in_data;
   logic [2:0]   in_bytes;
   logic [511:0] core_block;
   logic [159:0] core_digest, digest;
   logic         digest_valid, digest_ready, busy;

   sha1_msg_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
      .core_start(core_start), .core_first(core_first), .core_block(core_block),
      .core_done(core_done), .core_digest(core_digest),
      .digest_valid(digest_valid), .digest_ready(digest_ready),
      .digest(digest), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {t[30:0], t[31]};
      end
      a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
         else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
   endfunction

   // Reference SHA-1 of a byte string, padding done independently of the DUT.
   function automatic logic [159:0] sw_sha1(input bq_t m);
      bq_t          p;
      logic [63:0]  bl;
      logic [159:0] h;
      logic [511:0] b;
      p  = m;
      bl = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      h = IV;
      for (int k = 0; k < p.size() / 64; k++) begin
         for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
         h = sha1_compress(h, b);
      end
      return h;
   endfunction

   function automatic bq_t str_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
      return q;
   endfunction

   // Behavioural core: records each block, checks it is held, answers after 4 cycles.
   logic [511:0] blk_log [$];
   logic         first_log [$];
   int           start_cyc [$];
   int           stab_viol = 0;
   logic [159:0] h_model;

   initial begin : core_model
      logic [511:0] cap;
      logic         aborted;
      core_done   = 1'b0;
      core_digest = '0;
      h_model     = IV;
      forever begin
         @(posedge clk); #1;
         if (core_start && !rst) begin
            cap = core_block;
            blk_log.push_back(cap);
            first_log.push_back(core_first);
            start_cyc.push_back(cyc);
            if (core_first) h_model = IV;
            aborted = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(posedge clk); #1;
               if (rst) aborted = 1'b1;
               else if (!aborted && core_block !== cap) stab_viol++;
            end
            if (!aborted) begin
               h_model     = sha1_compress(h_model, cap);
               core_digest = h_model;
               core_done   = 1'b1;
               @(posedge clk); #1;
               core_done   = 1'b0;
            end
         end
      end
   end

   // Protocol monitor: no input acceptance while a block or digest is pending,
   // and no second start before core_done.
   int   proto_viol = 0;
   logic in_run = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         in_run = 1'b0;
      end else begin
         if (core_start) begin
            if (in_run) proto_viol++;
            in_run = 1'b1;
         end
         if ((in_run || digest_valid) && in_ready) proto_viol++;
         if (core_done) in_run = 1'b0;
      end
   end

   int last_acc_cyc = 0;

   // Drive a message as 32-bit beats; in_valid stays high while stalled.
   task automatic send_msg(input bq_t m, input logic with_last);
      int n, nw, rem, budget;
      logic [31:0] d;
      n  = m.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      for (int i = 0; i < nw; i++) begin
         d   = '0;
         rem = n - 4*i;
         for (int j = 0; j < 4; j++) if (4*i + j < n) d[31 - 8*j -: 8] = m[4*i + j];
         in_valid = 1'b1;
         in_data  = d;
         in_last  = with_last && (i == nw - 1);
         in_bytes = in_last ? 3'((rem > 4) ? 4 : rem) : 3'd4;
         budget   = 0;
         while (!in_ready && budget < 200) begin @(posedge clk); #1; budget++; end
         if (!in_ready) begin
            check("accept_timeout", 512'(in_ready), 512'd1);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         last_acc_cyc = cyc;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_digest(input string tag, input logic [159:0] exp, input int hold);
      int budget, bad;
      budget = 0;
      while (!digest_valid && budget < 2000) begin @(posedge clk); #1; budget++; end
      check({tag, "_dv"}, 512'(digest_valid), 512'd1);
      check({tag, "_digest"}, 512'(digest), 512'(exp));
      bad = 0;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (!digest_valid || digest !== exp) bad++;
      end
      check({tag, "_hold"}, 512'(bad), 512'd0);
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      check({tag, "_dv_low"}, 512'(digest_valid), 512'd0);
      check({tag, "_in_ready"}, 512'(in_ready), 512'd1);
      check({tag, "_busy_low"}, 512'(busy), 512'd0);
   endtask

   task automatic clear_logs();
      blk_log.delete();
      first_log.delete();
      start_cyc.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 512'(in_ready), 512'd0);
      check({tag, "_start"}, 512'({core_start, core_first}), 512'd0);
      check({tag, "_block"}, core_block, 512'd0);
      check({tag, "_dv"}, 512'(digest_valid), 512'd0);
      check({tag, "_digest"}, 512'(digest), 512'd0);
      check({tag, "_busy"}, 512'(busy), 512'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      bq_t m;
      int  budget;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
      digest_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ready", 512'(in_ready), 512'd1);
      check("sw_model_abc", 512'(sw_sha1(str_bytes("abc"))), 512'(D_ABC));

      // Empty message
      clear_logs();
      m.delete();
      send_msg(m, 1'b1);
      wait_digest("empty", D_EMPTY, 0);
      check("empty_nblk", 512'(blk_log.size()), 512'd1);
      check("empty_first", 512'(first_log[0]), 512'd1);
      check("empty_block", blk_log[0], {32'h8000_0000, 480'd0});
      check("empty_pad_lat", 512'(start_cyc[0] - last_acc_cyc), 512'd1);

      // "abc"
      clear_logs();
      send_msg(str_bytes("abc"), 1'b1);
      check("abc_busy", 512'(busy), 512'd1);
      wait_digest("abc", D_ABC, 0);
      check("abc_nblk", 512'(blk_log.size()), 512'd1);
      check("abc_w0", 512'(blk_log[0][511:480]), 512'h6162_6380);
      check("abc_w15", 512'(blk_log[0][31:0]), 512'h18);

      // 56 bytes: marker lands in word 14, length needs a second block
      clear_logs();
      send_msg(str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b1);
      wait_digest("m56", D_56, 0);
      check("m56_nblk", 512'(blk_log.size()), 512'd2);
      check("m56_first", 512'({first_log[0], first_log[1]}), 512'b10);
      check("m56_b0_w14", 512'(blk_log[0][63:32]), 512'h8000_0000);
      check("m56_b1_w15", 512'(blk_log[1][31:0]), 512'h1c0);
      check("m56_b1_w0", 512'(blk_log[1][511:480]), 512'd0);

      // 64 bytes: first block full, marker starts the second
      clear_logs();
      m.delete();
      for (int i = 0; i < 64; i++) m.push_back(u8'(i*7 + 3));
      send_msg(m, 1'b1);
      wait_digest("m64", sw_sha1(m), 0);
      check("m64_nblk", 512'(blk_log.size()), 512'd2);
      check("m64_b0_w0", 512'(blk_log[0][511:480]), 512'h030a_1118);
      check("m64_b1_w0", 512'(blk_log[1][511:480]), 512'h8000_0000);
      check("m64_b1_w15", 512'(blk_log[1][31:0]), 512'h200);
      check("m64_pad_lat", 512'(start_cyc[0] - last_acc_cyc), 512'd1);

      // Backpressure: stalled input across blocks, consumer slow by 10 cycles
      clear_logs();
      m.delete();
      for (int i = 0; i < 100; i++) m.push_back(u8'(255 - i*3));
      send_msg(m, 1'b1);
      wait_digest("bp", sw_sha1(m), 10);
      check("bp_nblk", 512'(blk_log.size()), 512'd2);
      check("bp_b1_w15", 512'(blk_log[1][31:0]), 512'h320);

      // Reset during block 2 of a longer message, then "abc"
      clear_logs();
      m.delete();
      for (int i = 0; i < 128; i++) m.push_back(u8'(i + 17));
      send_msg(m, 1'b0);
      budget = 0;
      while (start_cyc.size() < 2 && budget < 500) begin @(posedge clk); #1; budget++; end
      check("rst_blk2_started", 512'(start_cyc.size()), 512'd2);
      check("rst_blk2_lat", 512'(start_cyc[1] - last_acc_cyc), 512'd0);
      check("rst_blk2_first", 512'(first_log[1]), 512'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midrst");
      rst = 1'b0;
      clear_logs();
      budget = 0;
      while (!in_ready && budget < 20) begin @(posedge clk); #1; budget++; end
      send_msg(str_bytes("abc"), 1'b1);
      wait_digest("post_rst", D_ABC, 0);
      check("post_rst_nblk", 512'(blk_log.size()), 512'd1);
      check("post_rst_first", 512'(first_log[0]), 512'd1);

      check("block_stable", 512'(stab_viol), 512'd0);
      check("protocol", 512'(proto_viol), 512'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
